mem_stage_lsu: RTL and testbench

//  Parametrised pipeline memory stage between EXE and WB. Aligns sub-word loads/stores to data-bus lanes and sign/zero-extends loads.

---
 rtl/mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage between EXE and WB: lane-aligns sub-word loads/stores,
// extends load data, traps misaligned accesses and bounds the read wait.
module mem_stage_lsu #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_TRAP  = 1'b1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_reg_pc,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [4:0]      in_mem_wen,
  input  logic [3:0]      in_wb_sel,
  input  logic [4:0]      in_wb_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_read_data,
  output logic [XLEN-1:0] out_reg_pc,
  output logic [XLEN-1:0] out_alu_out,
  output logic [3:0]      out_wb_sel,
  output logic [4:0]      out_wb_addr,
  output logic            out_misaligned,
  output logic            out_timeout,
  output logic [2:0]      mem_cmd,
  input  logic            mem_cmd_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_wmask,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rdata_valid
);

  localparam logic [4:0] MEN_X   = 5'd0;
  localparam logic [4:0] MEN_LB  = 5'd1;
  localparam logic [4:0] MEN_LBU = 5'd2;
  localparam logic [4:0] MEN_LH  = 5'd3;
  localparam logic [4:0] MEN_LHU = 5'd4;
  localparam logic [4:0] MEN_LW  = 5'd5;
  localparam logic [4:0] MEN_SB  = 5'd6;
  localparam logic [4:0] MEN_SH  = 5'd7;
  localparam logic [4:0] MEN_SW  = 5'd8;

  localparam logic [2:0] MEMORY_CMD_NOP   = 3'd0;
  localparam logic [2:0] MEMORY_CMD_READ  = 3'd1;
  localparam logic [2:0] MEMORY_CMD_WRITE = 3'd2;

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_alu;
  logic [XLEN-1:0] cap_data;
  logic [4:0]      cap_wen;
  logic [3:0]      cap_wb_sel;
  logic [4:0]      cap_wb_addr;
  logic            cap_timeout;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             in_is_load;
  logic             in_is_store;
  logic [1:0]       in_size;
  logic [OFF_W-1:0] in_off;
  logic             in_misaligned;
  logic             in_trap;
  logic [XLEN-1:0]  in_wmask;
  logic [XLEN-1:0]  in_wdata;
  logic [OFF_W-1:0] cap_off;
  logic             cap_is_load;
  logic [XLEN-1:0]  rd_shifted;
  logic [XLEN-1:0]  rd_ext;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Decode the incoming op into direction, access size and lane placement.
  always_comb begin
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_size     = 2'd0;
    case (in_mem_wen)
      MEN_LB, MEN_LBU: begin in_is_load = 1'b1;  in_size = 2'd0; end
      MEN_LH, MEN_LHU: begin in_is_load = 1'b1;  in_size = 2'd1; end
      MEN_LW:          begin in_is_load = 1'b1;  in_size = 2'd2; end
      MEN_SB:          begin in_is_store = 1'b1; in_size = 2'd0; end
      MEN_SH:          begin in_is_store = 1'b1; in_size = 2'd1; end
      MEN_SW:          begin in_is_store = 1'b1; in_size = 2'd2; end
      default: ;
    endcase
    in_off        = in_alu_out[OFF_W-1:0];
    in_misaligned = (in_is_load || in_is_store) &&
                    (((in_size == 2'd1) && in_off[0]) ||
                     ((in_size == 2'd2) && (in_off[1:0] != 2'b00)));
    in_trap       = MISALIGN_TRAP && in_misaligned;
    case (in_size)
      2'd0: begin
        in_wmask = XLEN'(8'hFF) << {in_off, 3'b000};
        in_wdata = {(XLEN/8){in_rs2_data[7:0]}};
      end
      2'd1: begin
        in_wmask = XLEN'(16'hFFFF) << {in_off, 3'b000};
        in_wdata = {(XLEN/16){in_rs2_data[15:0]}};
      end
      default: begin
        in_wmask = XLEN'(32'hFFFF_FFFF) << {in_off, 3'b000};
        in_wdata = {(XLEN/32){in_rs2_data[31:0]}};
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend according to the load kind.
  always_comb begin
    cap_off     = cap_alu[OFF_W-1:0];
    cap_is_load = (cap_wen == MEN_LB) || (cap_wen == MEN_LBU) || (cap_wen == MEN_LH) ||
                  (cap_wen == MEN_LHU) || (cap_wen == MEN_LW);
    rd_shifted  = mem_rdata >> {cap_off, 3'b000};
    case (cap_wen)
      MEN_LB:  rd_ext = XLEN'($signed(rd_shifted[7:0]));
      MEN_LBU: rd_ext = XLEN'(rd_shifted[7:0]);
      MEN_LH:  rd_ext = XLEN'($signed(rd_shifted[15:0]));
      MEN_LHU: rd_ext = XLEN'(rd_shifted[15:0]);
      MEN_LW:  rd_ext = XLEN'($signed(rd_shifted[31:0]));
      default: rd_ext = '1;
    endcase
  end

  // Stage controller; the output bundle is only rewritten when a new result is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mem_cmd        <= MEMORY_CMD_NOP;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      out_valid      <= 1'b0;
      out_read_data  <= '0;
      out_reg_pc     <= '0;
      out_alu_out    <= '0;
      out_wb_sel     <= '0;
      out_wb_addr    <= '0;
      out_misaligned <= 1'b0;
      out_timeout    <= 1'b0;
      cap_pc         <= '0;
      cap_alu        <= '0;
      cap_data       <= '0;
      cap_wen        <= '0;
      cap_wb_sel     <= '0;
      cap_wb_addr    <= '0;
      cap_timeout    <= 1'b0;
      cnt            <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if ((!in_is_load && !in_is_store) || in_trap) begin
              out_valid      <= 1'b1;
              out_read_data  <= '1;
              out_reg_pc     <= in_reg_pc;
              out_alu_out    <= in_alu_out;
              out_wb_sel     <= in_wb_sel;
              out_wb_addr    <= in_wb_addr;
              out_misaligned <= in_trap;
              out_timeout    <= 1'b0;
            end else begin
              mem_cmd     <= in_is_load ? MEMORY_CMD_READ : MEMORY_CMD_WRITE;
              mem_addr    <= {in_alu_out[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata   <= in_wdata;
              mem_wmask   <= in_wmask;
              cap_pc      <= in_reg_pc;
              cap_alu     <= in_alu_out;
              cap_wen     <= in_mem_wen;
              cap_wb_sel  <= in_wb_sel;
              cap_wb_addr <= in_wb_addr;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // An accepted command beats a same-cycle flush.
          if (mem_cmd_ready) begin
            mem_cmd     <= MEMORY_CMD_NOP;
            cnt         <= '0;
            cap_data    <= '1;
            cap_timeout <= 1'b0;
            state       <= cap_is_load ? WAIT_RD : DONE;
          end else if (flush && cap_is_load) begin
            mem_cmd <= MEMORY_CMD_NOP;
            state   <= IDLE;
          end
        end
        WAIT_RD: begin
          if (mem_rdata_valid) begin
            cap_data    <= rd_ext;
            cap_timeout <= 1'b0;
            state       <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            cap_data    <= '1;
            cap_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid || out_ready) begin
            out_valid      <= 1'b1;
            out_read_data  <= cap_data;
            out_reg_pc     <= cap_pc;
            out_alu_out    <= cap_alu;
            out_wb_sel     <= cap_wb_sel;
            out_wb_addr    <= cap_wb_addr;
            out_misaligned <= 1'b0;
            out_timeout    <= cap_timeout;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (XLEN=32, trap on, timeout 4).
module tb_mem_stage_lsu;

  localparam int XLEN = 32;

  localparam logic [4:0] MEN_X   = 5'd0;
  localparam logic [4:0] MEN_LB  = 5'd1;
  localparam logic [4:0] MEN_LBU = 5'd2;
  localparam logic [4:0] MEN_LH  = 5'd3;
  localparam logic [4:0] MEN_LHU = 5'd4;
  localparam logic [4:0] MEN_LW  = 5'd5;
  localparam logic [4:0] MEN_SB  = 5'd6;
  localparam logic [4:0] MEN_SH  = 5'd7;
  localparam logic [4:0] MEN_SW  = 5'd8;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_reg_pc;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_alu_out;
  logic [4:0]      in_mem_wen;
  logic [3:0]      in_wb_sel;
  logic [4:0]      in_wb_addr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_read_data;
  logic [XLEN-1:0] out_reg_pc;
  logic [XLEN-1:0] out_alu_out;
  logic [3:0]      out_wb_sel;
  logic [4:0]      out_wb_addr;
  logic            out_misaligned;
  logic            out_timeout;
  logic [2:0]      mem_cmd;
  logic            mem_cmd_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_wmask;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rdata_valid;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  mem_stage_lsu #(.XLEN(XLEN), .MISALIGN_TRAP(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_pc(in_reg_pc), .in_rs2_data(in_rs2_data), .in_alu_out(in_alu_out),
    .in_mem_wen(in_mem_wen), .in_wb_sel(in_wb_sel), .in_wb_addr(in_wb_addr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_read_data(out_read_data), .out_reg_pc(out_reg_pc), .out_alu_out(out_alu_out),
    .out_wb_sel(out_wb_sel), .out_wb_addr(out_wb_addr),
    .out_misaligned(out_misaligned), .out_timeout(out_timeout),
    .mem_cmd(mem_cmd), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid        = 1'b0;
    flush           = 1'b0;
    mem_cmd_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    out_ready       = 1'b1;
  endtask

  task automatic present(input logic [4:0] wen, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc);
    in_valid    = 1'b1;
    in_mem_wen  = wen;
    in_alu_out  = addr;
    in_rs2_data = rs2;
    in_reg_pc   = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    in_reg_pc = '0; in_rs2_data = '0; in_alu_out = '0; in_mem_wen = MEN_X;
    in_wb_sel = 4'd0; in_wb_addr = 5'd0; mem_rdata = '0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (mem_cmd !== CMD_NOP) $display("[TB] FAIL reset_mem_cmd got %0d want 0", mem_cmd); else pass_cnt++;
    total_cnt++; if (out_read_data !== 32'h0) $display("[TB] FAIL reset_read_data got %h want 0", out_read_data); else pass_cnt++;
    total_cnt++; if (mem_wmask !== 32'h0) $display("[TB] FAIL reset_wmask got %h want 0", mem_wmask); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    logic [4:0]  wen_t  [5] = '{MEN_LB, MEN_LHU, MEN_LH, MEN_LBU, MEN_LW};
    logic [31:0] addr_t [5] = '{32'h1003, 32'h2002, 32'h2002, 32'h1001, 32'h5000};
    logic [31:0] rd_t   [5] = '{32'h80FF_FFFF, 32'hBEEF_1234, 32'hBEEF_1234, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] exp_t  [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0056, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      in_wb_sel  = 4'd1;
      in_wb_addr = 5'(i + 3);
      present(wen_t[i], addr_t[i], 32'h0, 32'h100 + 32'(i * 4));
      tick();
      in_valid = 1'b0;
      total_cnt++; if (mem_cmd !== CMD_READ) $display("[TB] FAIL load%0d_cmd got %0d want %0d", i, mem_cmd, CMD_READ); else pass_cnt++;
      total_cnt++; if (mem_addr !== (addr_t[i] & 32'hFFFF_FFFC)) $display("[TB] FAIL load%0d_addr got %h want %h", i, mem_addr, addr_t[i] & 32'hFFFF_FFFC); else pass_cnt++;
      mem_cmd_ready = 1'b1;
      tick();
      mem_cmd_ready   = 1'b0;
      mem_rdata       = rd_t[i];
      mem_rdata_valid = 1'b1;
      tick();
      mem_rdata_valid = 1'b0;
      mem_rdata       = 32'h0;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL load%0d_valid got %0b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_read_data !== exp_t[i]) $display("[TB] FAIL load%0d_data got %h want %h", i, out_read_data, exp_t[i]); else pass_cnt++;
      total_cnt++; if (out_reg_pc !== 32'h100 + 32'(i * 4)) $display("[TB] FAIL load%0d_pc got %h want %h", i, out_reg_pc, 32'h100 + 32'(i * 4)); else pass_cnt++;
      total_cnt++; if (out_wb_addr !== 5'(i + 3)) $display("[TB] FAIL load%0d_wb_addr got %0d want %0d", i, out_wb_addr, i + 3); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stores();
    logic [4:0]  wen_t  [2] = '{MEN_SB, MEN_SH};
    logic [31:0] addr_t [2] = '{32'h3001, 32'h3002};
    logic [31:0] rs2_t  [2] = '{32'h1234_56AB, 32'h0000_CAFE};
    logic [31:0] mask_t [2] = '{32'h0000_FF00, 32'hFFFF_0000};
    logic [31:0] wd_t   [2] = '{32'hABAB_ABAB, 32'hCAFE_CAFE};
    for (int i = 0; i < 2; i++) begin
      present(wen_t[i], addr_t[i], rs2_t[i], 32'h200);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        total_cnt++; if (mem_cmd !== CMD_WRITE) $display("[TB] FAIL store%0d_cmd_c%0d got %0d want %0d", i, k, mem_cmd, CMD_WRITE); else pass_cnt++;
        total_cnt++; if (mem_wmask !== mask_t[i]) $display("[TB] FAIL store%0d_wmask_c%0d got %h want %h", i, k, mem_wmask, mask_t[i]); else pass_cnt++;
        total_cnt++; if (mem_wdata !== wd_t[i]) $display("[TB] FAIL store%0d_wdata_c%0d got %h want %h", i, k, mem_wdata, wd_t[i]); else pass_cnt++;
        if (k < 2) tick();
      end
      total_cnt++; if (mem_addr !== 32'h3000) $display("[TB] FAIL store%0d_addr got %h want 00003000", i, mem_addr); else pass_cnt++;
      mem_cmd_ready = 1'b1;
      tick();
      mem_cmd_ready = 1'b0;
      total_cnt++; if (mem_cmd !== CMD_NOP) $display("[TB] FAIL store%0d_cmd_after got %0d want 0", i, mem_cmd); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL store%0d_valid got %0b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_read_data !== 32'hFFFF_FFFF) $display("[TB] FAIL store%0d_data got %h want ffffffff", i, out_read_data); else pass_cnt++;
      total_cnt++; if (out_alu_out !== addr_t[i]) $display("[TB] FAIL store%0d_alu got %h want %h", i, out_alu_out, addr_t[i]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_misaligned();
    present(MEN_LW, 32'h4002, 32'h0, 32'h300);
    tick();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (mem_cmd !== CMD_NOP) $display("[TB] FAIL mis_cmd got %0d want 0", mem_cmd); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL mis_valid got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_misaligned !== 1'b1) $display("[TB] FAIL mis_flag got %0b want 1", out_misaligned); else pass_cnt++;
    total_cnt++; if (out_read_data !== 32'hFFFF_FFFF) $display("[TB] FAIL mis_data got %h want ffffffff", out_read_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL mis_in_ready got %0b want 1", in_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    // No response at all: bundle five cycles after entering WAIT_RD.
    present(MEN_LW, 32'h6000, 32'h0, 32'h400);
    mem_cmd_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_cmd_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (n !== 5) $display("[TB] FAIL timeout_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (out_timeout !== 1'b1) $display("[TB] FAIL timeout_flag got %0b want 1", out_timeout); else pass_cnt++;
    total_cnt++; if (out_read_data !== 32'hFFFF_FFFF) $display("[TB] FAIL timeout_data got %h want ffffffff", out_read_data); else pass_cnt++;
    tick();
    // Data arriving in the final allowed cycle wins over the timeout.
    present(MEN_LW, 32'h6004, 32'h0, 32'h404);
    mem_cmd_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_cmd_ready = 1'b0;
    tick(); tick(); tick();
    mem_rdata       = 32'hCAFE_F00D;
    mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL edge_valid got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_timeout !== 1'b0) $display("[TB] FAIL edge_timeout got %0b want 0", out_timeout); else pass_cnt++;
    total_cnt++; if (out_read_data !== 32'hCAFE_F00D) $display("[TB] FAIL edge_data got %h want cafef00d", out_read_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    present(MEN_LW, 32'h7000, 32'h0, 32'h500);
    tick();
    in_valid = 1'b0;
    total_cnt++; if (mem_cmd !== CMD_READ) $display("[TB] FAIL flush_ld_cmd_before got %0d want 1", mem_cmd); else pass_cnt++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++; if (mem_cmd !== CMD_NOP) $display("[TB] FAIL flush_ld_cmd got %0d want 0", mem_cmd); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_ld_idle got %0b want 1", in_ready); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_ld_no_bundle got %0b want 0", out_valid); else pass_cnt++;
    // Stores in REQ are not cancelled.
    present(MEN_SW, 32'h7004, 32'h5555_AAAA, 32'h504);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++; if (mem_cmd !== CMD_WRITE) $display("[TB] FAIL flush_st_cmd got %0d want 2", mem_cmd); else pass_cnt++;
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL flush_st_bundle got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_reg_pc !== 32'h504) $display("[TB] FAIL flush_st_pc got %h want 00000504", out_reg_pc); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    in_wb_sel = 4'd7;
    present(MEN_X, 32'h0000_0003, 32'h0, 32'hA0);
    tick();
    total_cnt++; if (out_reg_pc !== 32'hA0) $display("[TB] FAIL b2b_pc0 got %h want 000000a0", out_reg_pc); else pass_cnt++;
    total_cnt++; if (out_misaligned !== 1'b0) $display("[TB] FAIL b2b_mis0 got %0b want 0", out_misaligned); else pass_cnt++;
    total_cnt++; if (out_wb_sel !== 4'd7) $display("[TB] FAIL b2b_wb_sel got %0d want 7", out_wb_sel); else pass_cnt++;
    present(MEN_X, 32'h0, 32'h0, 32'hA4);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready got %0b want 1", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_reg_pc !== 32'hA4) $display("[TB] FAIL b2b_pc1 got %h want 000000a4", out_reg_pc); else pass_cnt++;
    out_ready = 1'b0;
    present(MEN_X, 32'h0, 32'h0, 32'hA8);
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready_c%0d got %0b want 0", k, in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (out_reg_pc !== 32'hA4 || out_valid !== 1'b1) $display("[TB] FAIL stall_hold_c%0d got pc %h valid %0b want 000000a4 1", k, out_reg_pc, out_valid); else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out_reg_pc !== 32'hA8) $display("[TB] FAIL stall_release got %h want 000000a8", out_reg_pc); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drain got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    present(MEN_LW, 32'h8000, 32'h0, 32'h600);
    mem_cmd_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_cmd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (mem_cmd !== CMD_NOP) $display("[TB] FAIL rst_mid_cmd got %0d want 0", mem_cmd); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("[TB] FAIL rst_mid_addr got %h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (out_reg_pc !== 32'h0 || out_alu_out !== 32'h0) $display("[TB] FAIL rst_mid_bundle got pc %h alu %h want 0 0", out_reg_pc, out_alu_out); else pass_cnt++;
    rst_n = 1'b1;
    mem_rdata       = 32'h1111_2222;
    mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_dropped got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_mid_idle got %0b want 1", in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
